// File: rtl/sa_tile_ctrl_if.sv
// Host-side bundle of the tile sequencer: launch command, status and
// result-row writeback handshake.
interface sa_tile_ctrl_if #(
  parameter int NUM_ROW = 16,
  parameter int ADDR_W  = 10,
  parameter int K_W     = 10
);
  localparam int ROW_W = $clog2(NUM_ROW + 1);

  logic                start;
  logic [K_W-1:0]      k_len;
  logic [ADDR_W-1:0]   a_base;
  logic [ADDR_W-1:0]   b_base;
  logic                busy;
  logic                done;
  logic [NUM_ROW-1:0]  sa_row_out_valid;
  logic                out_valid;
  logic [ROW_W-1:0]    out_row;
  logic                out_ready;

  modport master (
    output start, k_len, a_base, b_base, out_ready,
    input  busy, done, sa_row_out_valid, out_valid, out_row
  );

  modport slave (
    input  start, k_len, a_base, b_base, out_ready,
    output busy, done, sa_row_out_valid, out_valid, out_row
  );
endinterface

// File: rtl/sa_tile_ctrl.sv
// Output-stationary systolic array tile sequencer: operand fetch with
// diagonal skew, per-PE capture pulses, then row-by-row result drain.
module sa_tile_ctrl #(
  parameter int DATA_W  = 8,
  parameter int NUM_ROW = 16,
  parameter int NUM_COL = 16,
  parameter int ADDR_W  = 10,
  parameter int K_W     = 10,
  parameter int PE_LAT  = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  sa_tile_ctrl_if.slave               ctl,
  output logic                        a_rd_en,
  output logic [ADDR_W-1:0]           a_rd_addr,
  input  logic [NUM_ROW*DATA_W-1:0]   a_rd_data,
  output logic                        b_rd_en,
  output logic [ADDR_W-1:0]           b_rd_addr,
  input  logic [NUM_COL*DATA_W-1:0]   b_rd_data,
  output logic                        sa_en,
  output logic [NUM_ROW*NUM_COL-1:0]  sa_clc,
  output logic [NUM_ROW*DATA_W-1:0]   sa_row_in,
  output logic [NUM_COL*DATA_W-1:0]   sa_col_in
);
  localparam int ROW_W = $clog2(NUM_ROW + 1);
  // Elapsed-cycle counter must reach K_max + 1 + PE_LAT + skew spans.
  localparam int CNT_W = $clog2((2 ** K_W) + NUM_ROW + NUM_COL + PE_LAT + 1);

  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, DRAIN, DONE} state_t;

  state_t             state, state_nx;
  logic [K_W-1:0]     k_len_q;
  logic [ADDR_W-1:0]  a_base_q, b_base_q;
  logic [K_W-1:0]     k_cnt;
  logic [CNT_W-1:0]   e_cnt;     // cycles since the accepted start
  logic [ROW_W-1:0]   row_cnt;
  logic               data_vld;  // read data on the buffer ports is a real element
  logic [CNT_W-1:0]   t_base;    // elapsed count of the PE(NUM_ROW,NUM_COL) capture
  logic [CNT_W-1:0]   t_last;    // elapsed count of the PE(1,1) capture

  assign t_base = CNT_W'(k_len_q) + CNT_W'(PE_LAT + 1);
  assign t_last = t_base + CNT_W'(NUM_ROW + NUM_COL - 2);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (ctl.start) state_nx = (ctl.k_len == '0) ? DONE : LOAD;
      LOAD:    if (k_cnt == k_len_q - K_W'(1)) state_nx = FLUSH;
      FLUSH:   if (e_cnt == t_last) state_nx = DRAIN;
      DRAIN:   if (ctl.out_ready && row_cnt == ROW_W'(1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Command capture, fetch/elapsed counters and drain row counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_len_q  <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
      k_cnt    <= '0;
      e_cnt    <= '0;
      row_cnt  <= '0;
      data_vld <= 1'b0;
    end else begin
      data_vld <= (state == LOAD);
      unique case (state)
        IDLE: if (ctl.start) begin
          k_len_q  <= ctl.k_len;
          a_base_q <= ctl.a_base;
          b_base_q <= ctl.b_base;
          k_cnt    <= '0;
          e_cnt    <= CNT_W'(1);
        end
        LOAD: begin
          k_cnt <= k_cnt + K_W'(1);
          e_cnt <= e_cnt + CNT_W'(1);
        end
        FLUSH: begin
          e_cnt   <= e_cnt + CNT_W'(1);
          row_cnt <= ROW_W'(NUM_ROW);
        end
        DRAIN: if (ctl.out_ready) row_cnt <= row_cnt - ROW_W'(1);
        default: ;
      endcase
    end
  end

  // Control outputs decoded from state
  always_comb begin
    ctl.busy             = (state != IDLE);
    ctl.done             = (state == DONE);
    a_rd_en              = (state == LOAD);
    b_rd_en              = (state == LOAD);
    a_rd_addr            = '0;
    b_rd_addr            = '0;
    sa_en                = (state == LOAD) || (state == FLUSH);
    ctl.out_valid        = (state == DRAIN);
    ctl.out_row          = '0;
    ctl.sa_row_out_valid = '0;
    if (state == LOAD) begin
      a_rd_addr = a_base_q + ADDR_W'(k_cnt);
      b_rd_addr = b_base_q + ADDR_W'(k_cnt);
    end
    if (state == DRAIN) begin
      ctl.out_row          = row_cnt;
      ctl.sa_row_out_valid = NUM_ROW'(1) << (row_cnt - ROW_W'(1));
    end
  end

  // Per-PE capture: PE(r,c) fires d_r + d_c cycles after PE(NUM_ROW,NUM_COL)
  for (genvar gr = 0; gr < NUM_ROW; gr++) begin : g_clc_r
    for (genvar gc = 0; gc < NUM_COL; gc++) begin : g_clc_c
      assign sa_clc[gr*NUM_COL + gc] = (state == FLUSH) &&
        (e_cnt == t_base + CNT_W'((NUM_ROW - 1 - gr) + (NUM_COL - 1 - gc)));
    end
  end

  // Row operand skew: lane r delayed by NUM_ROW - r cycles, zero when no element
  for (genvar gr = 0; gr < NUM_ROW; gr++) begin : g_row
    localparam int D  = NUM_ROW - 1 - gr;
    logic [DATA_W-1:0] lane_in;
    assign lane_in = data_vld ? a_rd_data[gr*DATA_W +: DATA_W] : '0;
    if (D == 0) begin : g_direct
      assign sa_row_in[gr*DATA_W +: DATA_W] = lane_in;
    end else begin : g_delay
      localparam int PW = D * DATA_W;
      logic [PW-1:0] pipe;
      // Shift register of depth D
      always_ff @(posedge clk) begin
        if (!rst_n) pipe <= '0;
        else        pipe <= (pipe << DATA_W) | PW'(lane_in);
      end
      assign sa_row_in[gr*DATA_W +: DATA_W] = pipe[PW-1 -: DATA_W];
    end
  end

  // Column operand skew: lane c delayed by NUM_COL - c cycles
  for (genvar gc = 0; gc < NUM_COL; gc++) begin : g_col
    localparam int D  = NUM_COL - 1 - gc;
    logic [DATA_W-1:0] lane_in;
    assign lane_in = data_vld ? b_rd_data[gc*DATA_W +: DATA_W] : '0;
    if (D == 0) begin : g_direct
      assign sa_col_in[gc*DATA_W +: DATA_W] = lane_in;
    end else begin : g_delay
      localparam int PW = D * DATA_W;
      logic [PW-1:0] pipe;
      // Shift register of depth D
      always_ff @(posedge clk) begin
        if (!rst_n) pipe <= '0;
        else        pipe <= (pipe << DATA_W) | PW'(lane_in);
      end
      assign sa_col_in[gc*DATA_W +: DATA_W] = pipe[PW-1 -: DATA_W];
    end
  end
endmodule

// File: tb/tb_sa_tile_ctrl.sv
// Scoreboard bench for sa_tile_ctrl: expected events are derived from the
// tile schedule rules and checked by an independent monitor.
module tb_sa_tile_ctrl;
  localparam int NR = 4, NC = 4, DW = 8, AW = 10, KW = 10, PL = 1;
  localparam int AD = 1 << AW;

  typedef struct { int t; int id; int v; int w; } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a_rd_en, b_rd_en, sa_en;
  logic [AW-1:0] a_rd_addr, b_rd_addr;
  logic [NR*DW-1:0] a_rd_data = '0;
  logic [NC*DW-1:0] b_rd_data = '0;
  logic [NR*NC-1:0] sa_clc;
  logic [NR*DW-1:0] sa_row_in;
  logic [NC*DW-1:0] sa_col_in;

  sa_tile_ctrl_if #(.NUM_ROW(NR), .ADDR_W(AW), .K_W(KW)) ctl ();

  sa_tile_ctrl #(.DATA_W(DW), .NUM_ROW(NR), .NUM_COL(NC), .ADDR_W(AW),
                 .K_W(KW), .PE_LAT(PL)) dut (
    .clk(clk), .rst_n(rst_n), .ctl(ctl),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
    .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
    .sa_en(sa_en), .sa_clc(sa_clc), .sa_row_in(sa_row_in), .sa_col_in(sa_col_in)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NR*DW-1:0] amem [AD];
  logic [NC*DW-1:0] bmem [AD];
  bit ready_low [65536];
  int stall [NR];
  ev_t rdq[$], enq[$], rowq[$], colq[$], clcq[$], drq[$], doneq[$];
  int n_cmp = 0, n_bad = 0;

  function automatic void chk(string name, bit ok, string got, string exp);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %s, expected %s", name, cyc, got, exp);
    end
  endfunction

  task automatic wait_cyc(int n);
    while (cyc < n) begin @(posedge clk); #1; end
  endtask

  function automatic void chk_quiet(string name);
    chk(name, !ctl.busy && !ctl.done && !a_rd_en && !b_rd_en && a_rd_addr == '0 &&
        b_rd_addr == '0 && !sa_en && sa_clc == '0 && sa_row_in == '0 && sa_col_in == '0 &&
        !ctl.out_valid && ctl.sa_row_out_valid == '0 && ctl.out_row == '0,
        $sformatf("busy %b done %b rd %b%b en %b clc %h row %h col %h ov %b", ctl.busy,
                  ctl.done, a_rd_en, b_rd_en, sa_en, sa_clc, sa_row_in, sa_col_in, ctl.out_valid),
        "all outputs zero");
  endfunction

  // Expected schedule of one tile launched in cycle s; returns the done cycle.
  task automatic push_model(int s, int k, int ab, int bb, output int dt);
    int t11, d, acc, vec, kk;
    if (k == 0) begin
      dt = s + 1;
      doneq.push_back('{t: dt, id: 0, v: 0, w: 0});
      return;
    end
    t11 = s + 2 + k - 1 + (NR - 1) + (NC - 1) + PL;
    for (int i = 0; i < k; i++)
      rdq.push_back('{t: s + 1 + i, id: 0, v: (ab + i) % AD, w: (bb + i) % AD});
    for (int t = s + 1; t <= t11; t++) enq.push_back('{t: t, id: 0, v: 0, w: 0});
    for (int t = s + 2; t <= s + 2 + k + NR; t++)
      for (int r = 1; r <= NR; r++) begin
        kk = t - (s + 2) - (NR - r);
        if (kk >= 0 && kk < k)
          rowq.push_back('{t: t, id: r, v: int'(amem[(ab + kk) % AD][(r-1)*DW +: DW]), w: 0});
      end
    for (int t = s + 2; t <= s + 2 + k + NC; t++)
      for (int c = 1; c <= NC; c++) begin
        kk = t - (s + 2) - (NC - c);
        if (kk >= 0 && kk < k)
          colq.push_back('{t: t, id: c, v: int'(bmem[(bb + kk) % AD][(c-1)*DW +: DW]), w: 0});
      end
    for (int t = s + 1; t <= t11; t++) begin
      vec = 0;
      for (int r = 1; r <= NR; r++)
        for (int c = 1; c <= NC; c++)
          if (t == s + 2 + k - 1 + (NR - r) + (NC - c) + PL) vec |= 1 << ((r-1)*NC + c - 1);
      if (vec != 0) clcq.push_back('{t: t, id: 0, v: vec, w: 0});
    end
    d = t11 + 1;
    for (int i = 0; i < NR; i++) begin
      acc = d + stall[i];
      for (int x = d; x < acc; x++) ready_low[x] = 1'b1;
      drq.push_back('{t: acc, id: NR - i, v: 0, w: 0});
      d = acc + 1;
    end
    dt = d;
    doneq.push_back('{t: dt, id: 0, v: 0, w: 0});
  endtask

  task automatic run_tile(int k, int ab, int bb, bit poke);
    int s, dt;
    s = cyc;
    ctl.start = 1'b1; ctl.k_len = KW'(k); ctl.a_base = AW'(ab); ctl.b_base = AW'(bb);
    push_model(s, k, ab, bb, dt);
    @(posedge clk); #1;
    ctl.start = 1'b0; ctl.k_len = KW'($urandom); ctl.a_base = AW'($urandom); ctl.b_base = AW'($urandom);
    chk("busy_after_start", ctl.busy == 1'b1, $sformatf("%b", ctl.busy), "1");
    if (poke && k > 0) begin
      ctl.start = 1'b1; ctl.k_len = KW'(5);
      @(posedge clk); #1;
      ctl.start = 1'b0;
    end
    wait_cyc(dt + 1);
    chk("busy_after_done", ctl.busy == 1'b0, $sformatf("%b", ctl.busy), "0");
    for (int i = 0; i < NR; i++) stall[i] = 0;
  endtask

  // Operand buffers: one-cycle read latency, junk on the bus when not read
  initial begin
    logic ra, rb;
    logic [AW-1:0] aa, ba;
    forever begin
      @(negedge clk);
      ra = a_rd_en; aa = a_rd_addr; rb = b_rd_en; ba = b_rd_addr;
      @(posedge clk); #1;
      if (ra) a_rd_data = amem[aa];
      else for (int j = 0; j < NR; j++) a_rd_data[j*DW +: DW] = DW'($urandom);
      if (rb) b_rd_data = bmem[ba];
      else for (int j = 0; j < NC; j++) b_rd_data[j*DW +: DW] = DW'($urandom);
    end
  end

  // Writeback ready driven from the planned stall table
  initial begin
    ctl.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      ctl.out_ready = !ready_low[cyc];
    end
  end

  // Monitor: pop and compare whenever the DUT shows an event
  initial begin
    ev_t e;
    int v;
    forever begin
      @(negedge clk);
      if (a_rd_en || b_rd_en) begin
        if (rdq.size() == 0) chk("rd_unexpected", 1'b0, $sformatf("read a %h", a_rd_addr), "no read");
        else begin
          e = rdq.pop_front();
          chk("rd", a_rd_en && b_rd_en && cyc == e.t && int'(a_rd_addr) == e.v && int'(b_rd_addr) == e.w,
              $sformatf("cyc %0d en %b%b a %h b %h", cyc, a_rd_en, b_rd_en, a_rd_addr, b_rd_addr),
              $sformatf("cyc %0d en 11 a %h b %h", e.t, e.v, e.w));
        end
      end
      if (sa_en) begin
        if (enq.size() == 0) chk("sa_en_unexpected", 1'b0, "sa_en 1", "sa_en 0");
        else begin
          e = enq.pop_front();
          chk("sa_en", cyc == e.t, $sformatf("cyc %0d", cyc), $sformatf("cyc %0d", e.t));
        end
      end
      for (int r = 1; r <= NR; r++) begin
        v = int'(sa_row_in[(r-1)*DW +: DW]);
        if (v != 0) begin
          if (rowq.size() == 0) chk("row_lane_unexpected", 1'b0, $sformatf("lane %0d = %0d", r, v), "0");
          else begin
            e = rowq.pop_front();
            chk("row_lane", cyc == e.t && r == e.id && v == e.v,
                $sformatf("cyc %0d lane %0d val %0d", cyc, r, v),
                $sformatf("cyc %0d lane %0d val %0d", e.t, e.id, e.v));
          end
        end
      end
      for (int c = 1; c <= NC; c++) begin
        v = int'(sa_col_in[(c-1)*DW +: DW]);
        if (v != 0) begin
          if (colq.size() == 0) chk("col_lane_unexpected", 1'b0, $sformatf("lane %0d = %0d", c, v), "0");
          else begin
            e = colq.pop_front();
            chk("col_lane", cyc == e.t && c == e.id && v == e.v,
                $sformatf("cyc %0d lane %0d val %0d", cyc, c, v),
                $sformatf("cyc %0d lane %0d val %0d", e.t, e.id, e.v));
          end
        end
      end
      if (sa_clc != '0) begin
        if (clcq.size() == 0) chk("clc_unexpected", 1'b0, $sformatf("clc %h", sa_clc), "0");
        else begin
          e = clcq.pop_front();
          chk("clc", cyc == e.t && int'(sa_clc) == e.v, $sformatf("cyc %0d clc %h", cyc, sa_clc),
              $sformatf("cyc %0d clc %h", e.t, e.v));
        end
      end
      if (ctl.out_valid) begin
        if (drq.size() == 0) chk("row_unexpected", 1'b0, $sformatf("row %0d", ctl.out_row), "no row");
        else begin
          e = drq[0];
          chk("row_sel", int'(ctl.out_row) == e.id && int'(ctl.sa_row_out_valid) == (1 << (e.id - 1)),
              $sformatf("row %0d sel %b", ctl.out_row, ctl.sa_row_out_valid),
              $sformatf("row %0d sel one-hot bit %0d", e.id, e.id - 1));
          if (ctl.out_ready) begin
            e = drq.pop_front();
            chk("row_accept", cyc == e.t, $sformatf("cyc %0d", cyc), $sformatf("cyc %0d", e.t));
          end
        end
      end else if (ctl.sa_row_out_valid != '0)
        chk("rowsel_idle", 1'b0, $sformatf("sel %b", ctl.sa_row_out_valid), "0");
      if (ctl.done) begin
        if (doneq.size() == 0) chk("done_unexpected", 1'b0, "done 1", "done 0");
        else begin
          e = doneq.pop_front();
          chk("done", cyc == e.t && ctl.busy, $sformatf("cyc %0d busy %b", cyc, ctl.busy),
              $sformatf("cyc %0d busy 1", e.t));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: still running at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int s, dt, k;
    ctl.start = 1'b0; ctl.k_len = '0; ctl.a_base = '0; ctl.b_base = '0;
    for (int i = 0; i < AD; i++)
      for (int j = 0; j < NR; j++) begin
        amem[i][j*DW +: DW] = DW'($urandom_range(1, 255));
        bmem[i][j*DW +: DW] = DW'($urandom_range(1, 255));
      end
    for (int i = 0; i < NR; i++) stall[i] = 0;

    wait_cyc(3);
    chk_quiet("reset_state");
    rst_n = 1'b1;

    wait_cyc(10);
    run_tile(3, 'h20, 'h40, 1'b0);          // reference timing tile
    stall[1] = 3;
    run_tile(3, 'h100, 'h180, 1'b0);        // backpressure on row 3, back-to-back
    run_tile(0, 'h10, 'h10, 1'b0);          // empty tile
    run_tile(3, 'h3FF, 'h3FE, 1'b1);        // address wrap, start poked while busy

    // Reset in the middle of FLUSH abandons the tile
    wait_cyc(cyc + 2);
    s = cyc;
    ctl.start = 1'b1; ctl.k_len = KW'(3); ctl.a_base = AW'('h20); ctl.b_base = AW'('h60);
    push_model(s, 3, 'h20, 'h60, dt);
    @(posedge clk); #1;
    ctl.start = 1'b0;
    wait_cyc(s + 7);
    rst_n = 1'b0;
    wait_cyc(s + 8);
    chk_quiet("reset_mid_flush");
    rdq.delete(); enq.delete(); rowq.delete(); colq.delete();
    clcq.delete(); drq.delete(); doneq.delete();
    for (int x = s; x < s + 64; x++) ready_low[x] = 1'b0;
    rst_n = 1'b1;
    wait_cyc(s + 10);
    run_tile(3, 'h220, 'h2A0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      k = (i == 5) ? 1023 : ((i % 7 == 3) ? 0 : int'($urandom_range(1, 12)));
      for (int j = 0; j < NR; j++) stall[j] = $urandom_range(0, 2);
      wait_cyc(cyc + int'($urandom_range(0, 2)));
      run_tile(k, $urandom_range(0, AD - 1), $urandom_range(0, AD - 1), (i % 4) == 1);
    end

    wait_cyc(cyc + 4);
    chk("leftover_events", (rdq.size() + enq.size() + rowq.size() + colq.size() + clcq.size() +
        drq.size() + doneq.size()) == 0,
        $sformatf("rd %0d en %0d row %0d col %0d clc %0d drain %0d done %0d", rdq.size(), enq.size(),
                  rowq.size(), colq.size(), clcq.size(), drq.size(), doneq.size()), "all empty");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
